// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size codes, exception codes and FSM state encoding
package mem_access_unit_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack memory bus between the load/store unit and a slave
// master drives req/we/addr/sel/wdata; slave returns ack and rdata (valid with ack)
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   sel;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;
  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: big-endian byte-lane select, store replication, load extract + extension
// ports: i_size/i_off/i_uns access shape; i_wdata store data; i_rdata bus word;
//        o_sel byte enables; o_wdata replicated store; o_rdata extended load result
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                   i_size,
  input  logic [$clog2(DATA_W/8)-1:0]  i_off,
  input  logic                         i_uns,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [DATA_W-1:0]            i_rdata,
  output logic [DATA_W/8-1:0]          o_sel,
  output logic [DATA_W-1:0]            o_wdata,
  output logic [DATA_W-1:0]            o_rdata
);
  localparam int NB = DATA_W / 8;
  int                w_nb;
  int                w_sh;
  int                w_bits;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_sign;
  always_comb begin
    w_nb    = (i_size == SZ_D && DATA_W == 32) ? 4 : 1 << i_size;
    w_bits  = 8 * w_nb;
    // offset 0 is the MSB lane, so the field sits this many bits above bit 0
    w_sh    = DATA_W - 8 * (int'(i_off) + w_nb);
    w_sh    = (w_sh < 0) ? 0 : w_sh;
    o_sel   = NB'(((1 << w_nb) - 1) << (NB - int'(i_off) - w_nb));
    o_wdata = (i_size == SZ_B) ? {NB{i_wdata[7:0]}} :
              (i_size == SZ_H) ? {(NB/2){i_wdata[15:0]}} :
              (i_size == SZ_W) ? {(NB/4){i_wdata[31:0]}} : i_wdata;
    w_shift = i_rdata >> w_sh;
    w_mask  = ~({DATA_W{1'b1}} << w_bits);
    // sign bit is the top bit of the mask, picked without a variable index
    w_sign  = !i_uns && |(w_shift & w_mask & ~(w_mask >> 1));
    o_rdata = (w_shift & w_mask) | ({DATA_W{w_sign}} & ~w_mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM-stage load/store unit, req/ack bus master
// ports: clk/rst_n (async active-low); flush_i; req_* pipeline request;
//        stall_o/done_o/rdata_o/exc_o completion; bus (mem_access_unit_if.master)
// optional LL/SC link bit enabled by `define MEM_ACCESS_LLSC_EN
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               req_valid_i,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_uns_i,
  input  logic               req_ll_i,
  input  logic               req_sc_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [DATA_W-1:0]  req_wdata_i,
  output logic               stall_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic [1:0]         exc_o,
  mem_access_unit_if.master  bus
);
  localparam int NB = DATA_W / 8;
  localparam int L  = $clog2(NB);
  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_uns, r_sc, r_kill;
  logic [1:0]        r_size, r_exc;
  logic [L-1:0]      r_off;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [NB-1:0]     w_sel;
  logic [DATA_W-1:0] w_wdata, w_ext;
  logic              w_accept, w_mis, w_sc_fail, w_timeout;
  assign w_accept  = r_state == S_IDLE && req_valid_i && !flush_i;
  // LL/SC of any size other than word is treated as an address error
  assign w_mis     = (req_size_i == SZ_H && req_addr_i[0]) ||
                     (req_size_i == SZ_W && |req_addr_i[1:0]) ||
                     (req_size_i == SZ_D && (DATA_W == 32 || |req_addr_i[2:0])) ||
                     ((req_ll_i || req_sc_i) && req_size_i != SZ_W);
  assign w_timeout = r_cnt == 8'(TIMEOUT - 1);
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size  (r_size),
    .i_off   (r_off),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .i_rdata (bus.rdata),
    .o_sel   (w_sel),
    .o_wdata (w_wdata),
    .o_rdata (w_ext)
  );
  assign bus.req   = r_state == S_BUSY;
  assign bus.we    = r_we;
  assign bus.addr  = r_addr;
  assign bus.sel   = (r_state == S_BUSY) ? w_sel : '0;
  assign bus.wdata = w_wdata;
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    done_o  = 1'b0;
    rdata_o = '0;
    exc_o   = EXC_NONE;
    w_next  = (r_state == S_IDLE) ? (w_accept ? ((w_mis || w_sc_fail) ? S_DONE : S_BUSY) : S_IDLE) :
              (r_state == S_BUSY) ? ((bus.ack || w_timeout) ? S_DONE : S_BUSY) : S_IDLE;
    stall_o = w_accept || (r_state == S_BUSY && !flush_i);
    done_o  = r_state == S_DONE && !r_kill;
    rdata_o = done_o ? r_rdata : '0;
    exc_o   = done_o ? r_exc : EXC_NONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_sc    <= 1'b0;
      r_kill  <= 1'b0;
      r_size  <= SZ_B;
      r_exc   <= EXC_NONE;
      r_off   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_BUSY) ? r_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_addr  <= {req_addr_i[ADDR_W-1:L], {L{1'b0}}};
        r_we    <= req_we_i;
        r_uns   <= req_uns_i;
        r_sc    <= req_sc_i;
        r_kill  <= 1'b0;
        r_size  <= req_size_i;
        r_off   <= req_addr_i[L-1:0];
        r_wdata <= req_wdata_i;
        r_rdata <= '0;
        r_exc   <= w_mis ? (req_we_i ? EXC_ADES : EXC_ADEL) : EXC_NONE;
      end
      if (r_state == S_BUSY) begin
        if (flush_i) r_kill <= 1'b1;
        if (bus.ack) r_rdata <= r_sc ? DATA_W'(1) : w_ext;
        else if (w_timeout) r_exc <= EXC_BUS;
      end
    end
  end
`ifdef MEM_ACCESS_LLSC_EN
  logic r_llbit, r_ll;
  assign w_sc_fail = req_sc_i && !r_llbit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ll    <= 1'b0;
      r_llbit <= 1'b0;
    end else begin
      if (w_accept) r_ll <= req_ll_i;
      if (flush_i) r_llbit <= 1'b0;
      else if (r_state == S_DONE && r_sc) r_llbit <= 1'b0;
      else if (r_state == S_DONE && r_ll && !r_kill && r_exc == EXC_NONE) r_llbit <= 1'b1;
    end
  end
`else
  assign w_sc_fail = 1'b0;
`endif
endmodule
